// File: rtl/cavlc_pkg.sv
// ---------------------------------------------------------------------------
// cavlc_pkg
// Shared widths, types and the debug status encoding for the CAVLC
// bitstream front end (cavlc_bit_window and cavlc_bit_merge).
// No ports; imported with import cavlc_pkg::*.
// ---------------------------------------------------------------------------
package cavlc_pkg;

  localparam int CAVLC_IN_W    = 32;
  localparam int CAVLC_WIN_W   = 32;
  localparam int CAVLC_BUF_W   = 64;
  localparam int CAVLC_SHIFT_W = 5;

  typedef logic [CAVLC_SHIFT_W-1:0] shift_amt_t;
  typedef logic [6:0]               bit_level_t;

  // Fill status of the bit buffer, derived purely from the level count.
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    PRIME  = 2'd1,
    ACTIVE = 2'd2,
    FULL   = 2'd3
  } status_e;

  // Maps a valid-bit count onto the status encoding.
  function automatic status_e levelToStatus(input bit_level_t level);
    status_e st;
    if (level == 7'd0) begin
      st = EMPTY;
    end else if (level < 7'd32) begin
      st = PRIME;
    end else if (level == 7'd32) begin
      st = ACTIVE;
    end else begin
      st = FULL;
    end
    return st;
  endfunction

endpackage

// File: rtl/cavlc_bit_merge.sv
// ---------------------------------------------------------------------------
// cavlc_bit_merge
// Combinational buffer update datapath: shifts the buffer left by the
// consumed amount and ORs a new word in at the post-shift fill point.
// Ports:
//   Buf_i      current buffer, valid bits left-aligned from the MSB
//   NumShift_i bits consumed this cycle (already gated to 0 if no shift)
//   Load_i     insert InData_i this cycle
//   InData_i   word to insert, bit 31 earliest
//   Fill_i     fill point after the shift (level minus shift amount)
//   Buf_o      next buffer contents
// ---------------------------------------------------------------------------
module cavlc_bit_merge
  import cavlc_pkg::*;
(
  input  logic [CAVLC_BUF_W-1:0] Buf_i,
  input  shift_amt_t             NumShift_i,
  input  logic                   Load_i,
  input  logic [CAVLC_IN_W-1:0]  InData_i,
  input  bit_level_t             Fill_i,
  output logic [CAVLC_BUF_W-1:0] Buf_o
);

  logic [CAVLC_BUF_W-1:0] shifted;
  logic [CAVLC_BUF_W-1:0] inserted;

  // Bits below the fill point are always zero because a left shift pulls in
  // zeros, so a plain OR is enough to place the new word.
  always_comb begin
    shifted  = Buf_i << NumShift_i;
    inserted = '0;
    if (Load_i) begin
      inserted = {InData_i, {CAVLC_WIN_W{1'b0}}} >> Fill_i;
    end
    Buf_o = shifted | inserted;
  end

endmodule

// File: rtl/cavlc_bit_window.sv
// ---------------------------------------------------------------------------
// cavlc_bit_window
// Bitstream front end of the CAVLC decoder. Buffers 32-bit input words
// MSB-first and presents a 32-bit bit-aligned window to the token and level
// decoders, advancing by NumShift_i bits on each accepted shift request.
//
// Optional feature (macro CAVLC_BITCOUNT_EN): adds ConsumedBits_o, a
// wrapping count of all bits consumed since reset or the last flush.
//
// Ports:
//   Clk                  clock, rising edge
//   nReset               asynchronous active-low reset
//   Flush_i              synchronous clear of all buffered bits
//   InValid_i / InData_i input word handshake (bit 31 earliest)
//   InReady_o            word accepted when InValid_i & InReady_o
//   ShiftEn_i/NumShift_i consume NumShift_i bits (0..31)
//   Window_o             next 32 unconsumed bits, bit 31 oldest
//   BarrelShifterReady_o Window_o fully valid (level >= 32)
//   Level_o              buffered valid bit count, 0..64
//   Status_o             debug status derived from the level
//   ConsumedBits_o       consumed-bit counter (CAVLC_BITCOUNT_EN only)
// ---------------------------------------------------------------------------
module cavlc_bit_window
  import cavlc_pkg::*;
(
  input  logic                   Clk,
  input  logic                   nReset,
  input  logic                   Flush_i,
  input  logic                   InValid_i,
  input  logic [CAVLC_IN_W-1:0]  InData_i,
  output logic                   InReady_o,
  input  logic                   ShiftEn_i,
  input  logic [4:0]             NumShift_i,
  output logic [CAVLC_WIN_W-1:0] Window_o,
  output logic                   BarrelShifterReady_o,
`ifdef CAVLC_BITCOUNT_EN
  output logic [31:0]            ConsumedBits_o,
`endif
  output logic [1:0]             Status_o,
  output logic [6:0]             Level_o
);

  logic [CAVLC_BUF_W-1:0] buf_q;
  logic [CAVLC_BUF_W-1:0] buf_d;
  logic [CAVLC_BUF_W-1:0] mergedBuf;
  bit_level_t             level_q;
  bit_level_t             level_d;
  bit_level_t             fillPoint;
  shift_amt_t             shiftAmt;
  logic                   loadFire;
  logic                   shiftFire;
  status_e                status;

  assign Window_o             = buf_q[CAVLC_BUF_W-1:CAVLC_BUF_W-CAVLC_WIN_W];
  assign BarrelShifterReady_o = (level_q >= 7'd32);
  assign InReady_o            = (level_q <= 7'd32) & ~Flush_i;
  assign Level_o              = level_q;
  assign status               = levelToStatus(level_q);
  assign Status_o             = status;

  assign loadFire  = InValid_i & InReady_o;
  assign shiftFire = ShiftEn_i & BarrelShifterReady_o;
  assign shiftAmt  = shiftFire ? NumShift_i : '0;

  // Shift is applied before the load, so the new word lands at level - n.
  // A load only happens with level <= 32, so the fill point never exceeds 32.
  assign fillPoint = level_q - {2'b00, shiftAmt};

  cavlc_bit_merge uMerge (
    .Buf_i      (buf_q),
    .NumShift_i (shiftAmt),
    .Load_i     (loadFire),
    .InData_i   (InData_i),
    .Fill_i     (fillPoint),
    .Buf_o      (mergedBuf)
  );

  // Flush overrides both the load and the shift.
  always_comb begin
    buf_d   = mergedBuf;
    level_d = fillPoint + (loadFire ? 7'd32 : 7'd0);
    if (Flush_i) begin
      buf_d   = '0;
      level_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      buf_q   <= '0;
      level_q <= '0;
    end else begin
      buf_q   <= buf_d;
      level_q <= level_d;
    end
  end

`ifdef CAVLC_BITCOUNT_EN
  logic [31:0] consumed_q;
  logic [31:0] consumed_d;

  // Wraps naturally modulo 2^32.
  always_comb begin
    consumed_d = consumed_q + {27'b0, shiftAmt};
    if (Flush_i) begin
      consumed_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      consumed_q <= '0;
    end else begin
      consumed_q <= consumed_d;
    end
  end

  assign ConsumedBits_o = consumed_q;
`endif

endmodule

// File: tb/tb_cavlc_bit_window.sv
// ---------------------------------------------------------------------------
// tb_cavlc_bit_window
// Self-checking bench for cavlc_bit_window. The reference model keeps the
// buffered bits as a queue of single bits: loads push 32 bits on the back,
// shifts pop bits off the front. Window, level and status are read off that
// queue. Directed table rows carry hand-computed expectations as well.
// Honours CAVLC_BITCOUNT_EN when defined.
// ---------------------------------------------------------------------------
module tb_cavlc_bit_window;
  import cavlc_pkg::*;

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  logic        Flush = 1'b0;
  logic        InValid = 1'b0;
  logic [31:0] InData = '0;
  logic        ShiftEn = 1'b0;
  logic [4:0]  NumShift = '0;
  logic        InReady;
  logic [31:0] Window;
  logic        BarrelShifterReady;
  logic [1:0]  Status;
  logic [6:0]  Level;
`ifdef CAVLC_BITCOUNT_EN
  logic [31:0] ConsumedBits;
`endif

  cavlc_bit_window dut (
    .Clk                  (Clk),
    .nReset               (nReset),
    .Flush_i              (Flush),
    .InValid_i            (InValid),
    .InData_i             (InData),
    .InReady_o            (InReady),
    .ShiftEn_i            (ShiftEn),
    .NumShift_i           (NumShift),
    .Window_o             (Window),
    .BarrelShifterReady_o (BarrelShifterReady),
`ifdef CAVLC_BITCOUNT_EN
    .ConsumedBits_o       (ConsumedBits),
`endif
    .Status_o             (Status),
    .Level_o              (Level)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          modelBits[$];
  int unsigned modelConsumed = 0;

  typedef struct {
    logic        fl;
    logic        v;
    logic [31:0] d;
    logic        se;
    logic [4:0]  ns;
    int          expLevel;
    logic [31:0] expWin;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] modelWindow();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < modelBits.size()) w[31-i] = modelBits[i];
    end
    return w;
  endfunction

  function automatic logic [31:0] levelMask(input int lvl);
    logic [31:0] allOnes;
    allOnes = 32'hFFFF_FFFF;
    return (lvl >= 32) ? allOnes : ~(allOnes >> lvl);
  endfunction

  // Drives one cycle of inputs, checks the combinational InReady, then
  // advances the model across the clock edge.
  task automatic applyStimulus(input logic fl, input logic v, input logic [31:0] d,
                               input logic se, input logic [4:0] ns);
    int  lvl;
    int  n;
    bit  ld;
    Flush = fl; InValid = v; InData = d; ShiftEn = se; NumShift = ns;
    #1;
    lvl = modelBits.size();
    check("InReady", {31'b0, InReady}, {31'b0, (lvl <= 32) && !fl});
    @(posedge Clk);
    if (fl) begin
      modelBits.delete();
      modelConsumed = 0;
    end else begin
      ld = v && (lvl <= 32);
      n  = (se && lvl >= 32) ? int'(ns) : 0;
      for (int k = 0; k < n; k++) void'(modelBits.pop_front());
      modelConsumed += n;
      if (ld) for (int i = 31; i >= 0; i--) modelBits.push_back(d[i]);
    end
    @(negedge Clk);
    Flush = 1'b0; InValid = 1'b0; ShiftEn = 1'b0;
  endtask

  task automatic checkOutput();
    int          lvl;
    logic [1:0]  expSt;
    lvl = modelBits.size();
    if (lvl == 0)       expSt = 2'd0;
    else if (lvl < 32)  expSt = 2'd1;
    else if (lvl == 32) expSt = 2'd2;
    else                expSt = 2'd3;
    check("Level", {25'b0, Level}, lvl);
    check("BarrelShifterReady", {31'b0, BarrelShifterReady}, {31'b0, lvl >= 32});
    check("Status", {30'b0, Status}, {30'b0, expSt});
    // Window bits beyond the level are don't-care except when empty.
    if (lvl == 0) check("WindowEmpty", Window, 32'h0);
    else          check("Window", Window & levelMask(lvl), modelWindow() & levelMask(lvl));
`ifdef CAVLC_BITCOUNT_EN
    check("ConsumedBits", ConsumedBits, modelConsumed);
`endif
  endtask

  initial begin
    //            fl    v     data          se    ns    lvl  window
    vecs[0]  = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 5'd0,  32, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 1'b1, 32'h12345678, 1'b0, 5'd0,  64, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'hAAAAAAAA, 1'b0, 5'd0,  64, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 5'd4,  60, 32'hEADBEEF1};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 5'd28, 32, 32'h12345678};
    vecs[5]  = '{1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 5'd8,  56, 32'h345678CA};
    vecs[6]  = '{1'b1, 1'b1, 32'h55555555, 1'b1, 5'd3,  0,  32'h0};
    vecs[7]  = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 5'd0,  32, 32'hDEADBEEF};
    vecs[8]  = '{1'b0, 1'b1, 32'h12345678, 1'b1, 5'd8,  56, 32'hADBEEF12};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,        1'b0, 5'd0,  0,  32'h0};
    vecs[10] = '{1'b0, 1'b1, 32'h13579BDF, 1'b0, 5'd0,  32, 32'h13579BDF};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 5'd16, 16, 32'h9BDF0000};
    vecs[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 5'd5,  16, 32'h9BDF0000};
    vecs[13] = '{1'b0, 1'b1, 32'hFFFF0000, 1'b0, 5'd0,  48, 32'h9BDFFFFF};
    vecs[14] = '{1'b1, 1'b1, 32'h87654321, 1'b1, 5'd7,  0,  32'h0};

    // Reset state
    nReset = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    checkOutput();
    check("InReadyReset", {31'b0, InReady}, 32'd1);
    nReset = 1'b1;
    @(negedge Clk);

    // Directed table
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].fl, vecs[i].v, vecs[i].d, vecs[i].se, vecs[i].ns);
      checkOutput();
      check($sformatf("TableLevel[%0d]", i), {25'b0, Level}, vecs[i].expLevel);
      check($sformatf("TableWindow[%0d]", i), Window & levelMask(vecs[i].expLevel),
            vecs[i].expWin & levelMask(vecs[i].expLevel));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 40) == 0, $urandom_range(0, 2) != 0, $urandom,
                    $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)));
      checkOutput();
    end

    // Asynchronous reset in the middle of a cycle with data buffered
    applyStimulus(1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 5'd0);
    #2;
    nReset = 1'b0;
    #1;
    modelBits.delete();
    modelConsumed = 0;
    checkOutput();
    check("InReadyAsyncReset", {31'b0, InReady}, 32'd1);
    @(negedge Clk);
    nReset = 1'b1;
    @(negedge Clk);
    applyStimulus(1'b0, 1'b1, 32'h0F0F1234, 1'b0, 5'd0);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 5'd31);
    checkOutput();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cavlc_bit_window.md
Name: cavlc_bit_window

Overview:
- Bitstream front end of the CAVLC decoder. Sits directly upstream of the CAVLC control FSM.
- Accepts packed 32-bit bitstream words from the input fetcher and buffers them MSB-first.
- Presents a 32-bit bit-aligned window to the coeff-token and level decoders.
- Consumes the FSM's ShiftEn/NumShift requests to advance the bit position. Asserts BarrelShifterReady while a full window is valid.

Parameters:
- IN_W, 32, input word width in bits.
- WIN_W, 32, output window width in bits.
- BUF_W, 64, internal buffer width; must equal IN_W + WIN_W.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- nReset  in  1  asynchronous, active-low reset.
- Flush  in  1  synchronous clear of all buffered bits (slice/block restart).
- InValid  in  1  InData valid.
- InData  in  IN_W  next bitstream word; bit 31 is the earliest bit.
- InReady  out  1  word accepted on a cycle with InValid & InReady.
- ShiftEn  in  1  consume NumShift bits this cycle.
- NumShift  in  5  bits to consume, 0..31.
- Window  out  WIN_W  next WIN_W unconsumed bits; bit 31 is the oldest bit.
- BarrelShifterReady  out  1  Window fully valid (Level >= WIN_W).
- Level  out  7  number of buffered valid bits, 0..64.

Behaviour:
- State: Buf[BUF_W-1:0] holds valid bits left-aligned from bit 63. Level[6:0] holds the valid-bit count.
- Reset: Buf=0, Level=0. Therefore Window=0, BarrelShifterReady=0, InReady=1.
- Window = Buf[63:32], combinational from registers. Bits below Level are don't-care but must be zero after reset or Flush.
- BarrelShifterReady = (Level >= 32).
- InReady = (Level <= 32) & !Flush.
- Status encoding, derived from Level and exported for debug only:
  - EMPTY: Level=0.
  - PRIME: 0<Level<32.
  - ACTIVE: 32<=Level<=32, i.e. input still accepted.
  - FULL: Level>32.
  - Transitions follow directly from the Level update rules below.
- Load (Ld = InValid & InReady) and shift (Sh = ShiftEn & BarrelShifterReady) are evaluated in the same cycle. Let n = Sh ? NumShift : 0.
  - Buf_next = (Buf << n) | (Ld ? ({InData, 32'b0} >> (Level - n)) : 0).
  - Level_next = Level - n + (Ld ? 32 : 0).
  - Level - n <= 32 is guaranteed whenever Ld=1, so the load never overflows.
  - The shift is applied first, then the word is inserted at the new fill point. This is a single-cycle operation.
- Latency:
  - A loaded word is visible in Window the cycle after acceptance.
  - A shift is reflected in Window the cycle after ShiftEn.
- ShiftEn while BarrelShifterReady=0: ignored; Buf and Level are unchanged.
- NumShift=0 with ShiftEn=1: no-op shift. A load on the same cycle still proceeds.
- Level cannot go negative: Sh requires Level>=32 and NumShift<=31.
- Flush has priority over load and shift: next cycle Buf=0, Level=0. A coincident InData word is dropped, because InReady=0 during Flush.
- Reset mid-operation clears all state immediately (asynchronous). No partial word survives.
- Level is 7 bits, range 0..64, and never wraps.

Optional Feature:
- Macro: CAVLC_BITCOUNT_EN.
- Defined:
  - Adds output ConsumedBits[31:0]. Reset value 0.
  - Increments by n on every accepted shift. Wraps modulo 2^32.
  - Cleared by Flush. Used for slice-level bit accounting and debug.
- Undefined:
  - Port and counter are absent.
  - Core behaviour is identical.

Decomposition:
- Shared package cavlc_pkg:
  - CAVLC_IN_W=32, CAVLC_WIN_W=32, CAVLC_BUF_W=64.
  - CAVLC_SHIFT_W=5.
  - typedef logic [4:0] shift_amt_t.
  - typedef logic [6:0] bit_level_t.
  - Status enum {EMPTY, PRIME, ACTIVE, FULL}.
- One sub-module is natural: cavlc_bit_merge. It is the combinational shift-left-by-n plus insert-word-at-offset datapath. This keeps the top level to the registers, handshake and Level bookkeeping.

Test Plan:
- Reset, then InData=0xDEADBEEF for one cycle -> next cycle Level=32, BarrelShifterReady=1, Window=0xDEADBEEF, InReady=1.
- Load 0xDEADBEEF then 0x12345678 back-to-back -> Level=64, InReady=0. A third word is held off until a shift drops Level to <=32.
- Level=64 as above, ShiftEn with NumShift=4 -> Window=0xEADBEEF1, Level=60, InReady=0.
- Level=32, Window=0xDEADBEEF, ShiftEn NumShift=8 and InValid 0x12345678 in the same cycle -> Window=0xADBEEF12, Level=56.
- Level=16 (PRIME), ShiftEn NumShift=5 -> ignored: Level=16, Window unchanged, BarrelShifterReady=0.
- Level=48, Flush with InValid=1 and ShiftEn=1 -> InReady=0 that cycle; next cycle Level=0, Window=0, ConsumedBits=0 (if CAVLC_BITCOUNT_EN is defined).
